// File: rtl/fir_mac_sequencer_if.sv
// fir_mac_sequencer_if
//   Bundles the sample stream, the result stream, the coefficient write port
//   and the busy flag of the FIR MAC sequencer.
//   Ports (slave = the sequencer, master = whatever drives it):
//     s_axis_data_tvalid/tready/tdata : input sample stream (DW bits, signed)
//     m_axis_data_tvalid/tready/tdata : saturated result stream (OW bits, signed)
//     coef_we/coef_addr/coef_data     : coefficient bank write port
//     busy                            : high whenever the sequencer is not idle
interface fir_mac_sequencer_if #(
  parameter int DW  = 16,
  parameter int OW  = 34,
  parameter int CAW = 5
);
  logic           s_axis_data_tvalid;
  logic           s_axis_data_tready;
  logic [DW-1:0]  s_axis_data_tdata;
  logic           m_axis_data_tvalid;
  logic           m_axis_data_tready;
  logic [OW-1:0]  m_axis_data_tdata;
  logic           coef_we;
  logic [CAW-1:0] coef_addr;
  logic [DW-1:0]  coef_data;
  logic           busy;

  modport slave (
    input  s_axis_data_tvalid, s_axis_data_tdata, m_axis_data_tready,
           coef_we, coef_addr, coef_data,
    output s_axis_data_tready, m_axis_data_tvalid, m_axis_data_tdata, busy
  );

  modport master (
    output s_axis_data_tvalid, s_axis_data_tdata, m_axis_data_tready,
           coef_we, coef_addr, coef_data,
    input  s_axis_data_tready, m_axis_data_tvalid, m_axis_data_tdata, busy
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
//   Time-multiplexed FIR: one sample is accepted in IDLE, then NTAPS
//   multiply-accumulate cycles walk the circular delay line against the
//   coefficient bank, and the saturated sum is offered in OUT until taken.
//   Ports:
//     aclk   : clock, rising edge
//     areset : asynchronous active-high reset
//     bus    : fir_mac_sequencer_if.slave (sample/result streams, coefficient
//              write port, busy)
//   All outputs come straight from flops.
module fir_mac_sequencer #(
  parameter int NTAPS = 32,
  parameter int DW    = 16,
  parameter int OW    = 34
) (
  input  logic               aclk,
  input  logic               areset,
  fir_mac_sequencer_if.slave bus
);
  localparam int PW  = $clog2(NTAPS);
  localparam int PPW = 2 * DW;
  localparam int AW  = PPW + PW;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] LAST_TAP = PW'(NTAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  // Clamp the accumulator into the signed OW-bit output range. The value fits
  // when every bit from OW-1 upward equals the sign bit.
  function automatic logic [OW-1:0] sat_acc(input logic [AW-1:0] a);
    logic [AW-OW:0] top;
    logic [OW-1:0]  r;
    top = a[AW-1:OW-1];
    if ((top == {(AW-OW+1){1'b0}}) || (top == {(AW-OW+1){1'b1}})) begin
      r = a[OW-1:0];
    end else if (a[AW-1]) begin
      r = {1'b1, {(OW-1){1'b0}}};
    end else begin
      r = {1'b0, {(OW-1){1'b1}}};
    end
    return r;
  endfunction

  state_e                state_q, state_d;
  logic [PW-1:0]         k_q, k_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic                  s_tready_q, s_tready_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic [OW-1:0]         m_tdata_q, m_tdata_d;
  logic                  busy_q, busy_d;
  logic signed [DW-1:0]  x_q [NTAPS];
  logic signed [DW-1:0]  c_q [NTAPS];
  logic                  x_we;
  logic                  c_we;
  logic [PW-1:0]         tap_idx;
  logic signed [PPW-1:0] prod;
  logic signed [AW-1:0]  acc_sum;

  // Newest sample sits at wr_ptr, so tap k reads wr_ptr-k; the pointer width
  // makes the subtraction wrap around the delay line for free.
  assign tap_idx = wr_ptr_q - k_q;
  assign prod    = PPW'(x_q[tap_idx]) * PPW'(c_q[k_q]);
  assign acc_sum = acc_q + AW'(prod);

  assign bus.s_axis_data_tready = s_tready_q;
  assign bus.m_axis_data_tvalid = m_tvalid_q;
  assign bus.m_axis_data_tdata  = m_tdata_q;
  assign bus.busy               = busy_q;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    wr_ptr_d   = wr_ptr_q;
    acc_d      = acc_q;
    s_tready_d = s_tready_q;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    busy_d     = busy_q;
    x_we       = 1'b0;
    c_we       = 1'b0;

    // Coefficients are only writable while idle; writes in MAC/OUT are dropped.
    if (bus.coef_we && (state_q == S_IDLE)) begin
      c_we = 1'b1;
    end else begin
      c_we = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.s_axis_data_tvalid && s_tready_q) begin
          x_we       = 1'b1;
          acc_d      = {AW{1'b0}};
          k_d        = {PW{1'b0}};
          state_d    = S_MAC;
          s_tready_d = 1'b0;
          busy_d     = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MAC: begin
        acc_d = acc_sum;
        k_d   = k_q + PTR_ONE;
        // The result register is loaded from the final sum on the last tap so
        // that tdata is already stable when tvalid rises.
        if (k_q == LAST_TAP) begin
          state_d    = S_OUT;
          m_tvalid_d = 1'b1;
          m_tdata_d  = sat_acc(acc_sum);
        end else begin
          state_d = S_MAC;
        end
      end
      S_OUT: begin
        if (m_tvalid_q && bus.m_axis_data_tready) begin
          wr_ptr_d   = wr_ptr_q + PTR_ONE;
          state_d    = S_IDLE;
          m_tvalid_d = 1'b0;
          s_tready_d = 1'b1;
          busy_d     = 1'b0;
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d    = S_IDLE;
        s_tready_d = 1'b1;
        m_tvalid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // Control state, accumulator and output registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= S_IDLE;
      k_q        <= {PW{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      acc_q      <= {AW{1'b0}};
      s_tready_q <= 1'b1;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= {OW{1'b0}};
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      wr_ptr_q   <= wr_ptr_d;
      acc_q      <= acc_d;
      s_tready_q <= s_tready_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      busy_q     <= busy_d;
    end
  end

  // Delay line and coefficient bank; both clear on reset so history reads as 0
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NTAPS; i++) begin
        x_q[i] <= {DW{1'b0}};
        c_q[i] <= {DW{1'b0}};
      end
    end else begin
      if (x_we) begin
        x_q[wr_ptr_q] <= bus.s_axis_data_tdata;
      end
      if (c_we) begin
        c_q[bus.coef_addr] <= bus.coef_data;
      end
    end
  end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer
//   Self-checking bench for fir_mac_sequencer at default parameters. A small
//   reference model (delay line, coefficients, write pointer) produces the
//   expected result of each accepted sample and pushes it on a scoreboard
//   queue; the result is popped and compared when the DUT raises tvalid.
//   Table vectors carry hand-derived expected values instead of the model's.
module tb_fir_mac_sequencer;
  localparam int NTAPS = 32;
  localparam int DW    = 16;
  localparam int OW    = 34;
  localparam int PW    = $clog2(NTAPS);
  localparam longint SAT_MAX = 64'sd8589934591;
  localparam longint SAT_MIN = -64'sd8589934592;

  typedef struct {
    int     sample;
    longint exp_y;
  } vec_t;

  logic aclk;
  logic areset;
  int   checks = 0;
  int   errors = 0;

  int     mx [NTAPS];
  int     mc [NTAPS];
  int     mptr;
  longint sb_q [$];
  vec_t   tbl [12];

  fir_mac_sequencer_if #(.DW(DW), .OW(OW), .CAW(PW)) bus ();

  fir_mac_sequencer #(.NTAPS(NTAPS), .DW(DW), .OW(OW)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic longint model_y();
    longint acc = 0;
    for (int k = 0; k < NTAPS; k++) begin
      acc += longint'(mc[k]) * longint'(mx[(mptr - k) & (NTAPS - 1)]);
    end
    if (acc > SAT_MAX) acc = SAT_MAX;
    else if (acc < SAT_MIN) acc = SAT_MIN;
    return acc;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NTAPS; i++) begin
      mx[i] = 0;
      mc[i] = 0;
    end
    mptr = 0;
  endtask

  // Called and returns at a negedge; DUT is idle.
  task automatic write_coef(input int addr, input int data);
    bus.coef_we   = 1'b1;
    bus.coef_addr = addr[PW-1:0];
    bus.coef_data = data[DW-1:0];
    @(negedge aclk);
    bus.coef_we = 1'b0;
    mc[addr] = data;
  endtask

  // One full transaction. mode 1: c[0]=100 write attempted during MAC.
  // mode 2: c[0]=100 written in the accept cycle. hold>0: m_tready held low
  // for hold cycles in OUT with sample nxt offered halfway through.
  task automatic run_sample(input int s, input int hold, input int mode,
                            input bit use_exp, input longint exp_y,
                            input int nxt, output longint obs);
    int n;
    int lat;
    longint expv;
    logic [OW-1:0] d0;
    bus.s_axis_data_tvalid = 1'b1;
    bus.s_axis_data_tdata  = s[DW-1:0];
    n = 0;
    while (bus.s_axis_data_tready !== 1'b1 && n < 100) begin
      @(negedge aclk);
      n++;
    end
    chk("s_tready_idle", bus.s_axis_data_tready, 1);
    if (mode == 2) begin
      bus.coef_we   = 1'b1;
      bus.coef_addr = {PW{1'b0}};
      bus.coef_data = 16'sd100;
      mc[0] = 100;
    end
    mx[mptr] = s;
    sb_q.push_back(use_exp ? exp_y : model_y());
    @(posedge aclk);
    @(negedge aclk);
    bus.s_axis_data_tvalid = 1'b0;
    bus.coef_we = 1'b0;
    chk("busy_after_accept", bus.busy, 1);
    chk("s_tready_busy", bus.s_axis_data_tready, 0);
    if (mode == 1) begin
      bus.coef_we   = 1'b1;
      bus.coef_addr = {PW{1'b0}};
      bus.coef_data = 16'sd100;
    end
    lat = 0;
    while (bus.m_axis_data_tvalid !== 1'b1 && lat < 200) begin
      @(negedge aclk);
      lat++;
      if (lat == 3) bus.coef_we = 1'b0;
    end
    bus.coef_we = 1'b0;
    chk("latency", lat, NTAPS);
    chk("sb_nonempty", sb_q.size() > 0, 1);
    expv = (sb_q.size() > 0) ? sb_q.pop_front() : 64'sd0;
    obs = longint'($signed(bus.m_axis_data_tdata));
    chk("y", obs, expv);
    d0 = bus.m_axis_data_tdata;
    for (int i = 0; i < hold; i++) begin
      if (i == hold / 2) begin
        bus.s_axis_data_tvalid = 1'b1;
        bus.s_axis_data_tdata  = nxt[DW-1:0];
      end
      @(negedge aclk);
      chk("hold_tvalid", bus.m_axis_data_tvalid, 1);
      chk("hold_tdata", bus.m_axis_data_tdata, d0);
      chk("hold_s_tready", bus.s_axis_data_tready, 0);
      chk("hold_busy", bus.busy, 1);
    end
    bus.m_axis_data_tready = 1'b1;
    @(negedge aclk);
    bus.m_axis_data_tready = 1'b0;
    mptr = (mptr + 1) % NTAPS;
    chk("post_hs_tvalid", bus.m_axis_data_tvalid, 0);
    chk("post_hs_busy", bus.busy, 0);
    chk("post_hs_s_tready", bus.s_axis_data_tready, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_tready"}, bus.s_axis_data_tready, 1);
    chk({tag, "_m_tvalid"}, bus.m_axis_data_tvalid, 0);
    chk({tag, "_m_tdata"}, bus.m_axis_data_tdata, 0);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    longint obs;
    int n;
    int seen;

    // Impulse 1,0,0,0,0 then ramp 1..7, with c = {1,2,3,4,0,...}.
    tbl[0]  = '{1, 64'sd1};
    tbl[1]  = '{0, 64'sd2};
    tbl[2]  = '{0, 64'sd3};
    tbl[3]  = '{0, 64'sd4};
    tbl[4]  = '{0, 64'sd0};
    tbl[5]  = '{1, 64'sd1};
    tbl[6]  = '{2, 64'sd4};
    tbl[7]  = '{3, 64'sd10};
    tbl[8]  = '{4, 64'sd20};
    tbl[9]  = '{5, 64'sd30};
    tbl[10] = '{6, 64'sd40};
    tbl[11] = '{7, 64'sd50};

    areset = 1'b1;
    bus.s_axis_data_tvalid = 1'b0;
    bus.s_axis_data_tdata  = {DW{1'b0}};
    bus.m_axis_data_tready = 1'b0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = {PW{1'b0}};
    bus.coef_data = {DW{1'b0}};
    model_clear();
    repeat (2) @(negedge aclk);
    chk_reset_outputs("reset");
    areset = 1'b0;
    @(negedge aclk);

    // Impulse and ramp from the table.
    for (int i = 0; i < 4; i++) write_coef(i, i + 1);
    for (int i = 0; i < 12; i++) run_sample(tbl[i].sample, 0, 0, 1'b1, tbl[i].exp_y, 0, obs);

    // Coefficient write while busy is dropped; the same write in IDLE lands.
    run_sample(5, 0, 1, 1'b0, 0, 0, obs);
    run_sample(6, 0, 0, 1'b0, 0, 0, obs);
    write_coef(0, 100);
    run_sample(7, 0, 0, 1'b0, 0, 0, obs);
    write_coef(0, 1);
    run_sample(8, 0, 2, 1'b0, 0, 0, obs);
    write_coef(0, 1);

    // Backpressure: 20 cycles of m_tready low, next sample offered meanwhile.
    run_sample(9, 20, 0, 1'b0, 0, -3, obs);
    run_sample(-3, 0, 0, 1'b0, 0, 0, obs);

    // Positive and negative saturation with all coefficients at 32767.
    for (int i = 0; i < NTAPS; i++) write_coef(i, 32767);
    for (int i = 0; i < 40; i++) begin
      run_sample(32767, 0, 0, 1'b0, 0, 0, obs);
      if (i >= 31) chk("sat_pos", obs, SAT_MAX);
    end
    for (int i = 0; i < 40; i++) begin
      run_sample(-32768, 0, 0, 1'b0, 0, 0, obs);
      if (i >= 31) chk("sat_neg", obs, SAT_MIN);
    end

    // Ramp again, positioned so the write pointer wraps 31 -> 0 mid-ramp.
    for (int i = 0; i < NTAPS; i++) write_coef(i, (i < 4) ? i + 1 : 0);
    n = 0;
    while (n < 3 || mptr != 29) begin
      run_sample(0, 0, 0, 1'b0, 0, 0, obs);
      n++;
    end
    for (int i = 5; i < 12; i++) run_sample(tbl[i].sample, 0, 0, 1'b1, tbl[i].exp_y, 0, obs);

    // Reset at MAC cycle 10: outputs clear at once, no result follows.
    bus.s_axis_data_tvalid = 1'b1;
    bus.s_axis_data_tdata  = 16'sd5;
    @(posedge aclk);
    @(negedge aclk);
    bus.s_axis_data_tvalid = 1'b0;
    chk("mid_busy", bus.busy, 1);
    repeat (10) @(negedge aclk);
    areset = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    model_clear();
    @(negedge aclk);
    areset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge aclk);
      if (bus.m_axis_data_tvalid === 1'b1) seen++;
    end
    chk("no_tvalid_after_reset", seen, 0);
    for (int i = 0; i < 5; i++) begin
      run_sample(tbl[i].sample, 0, 0, 1'b0, 0, 0, obs);
      chk("post_reset_impulse", obs, 0);
    end

    chk("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
